// File: rtl/iterative_normalizer.sv
// Iterative normalizer: shifts an operand left one bit per cycle until its MSB is set.
// Optional macro NORM_ZERO_FLAG_EN adds a registered out_zero flag for zero operands.
module iterative_normalizer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_valid,
    input  logic             out_ready
`ifdef NORM_ZERO_FLAG_EN
    ,
    output logic             out_zero
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] work;
    logic [CNT_W-1:0] cnt;
    logic             zero_flag;

    // A zero operand skips SHIFT entirely; its count is reported as WIDTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            work      <= '0;
            cnt       <= '0;
            zero_flag <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work <= in_data;
                        if (in_data == '0) begin
                            cnt       <= CNT_FULL;
                            zero_flag <= 1'b1;
                            state     <= ST_DONE;
                        end else begin
                            cnt       <= '0;
                            zero_flag <= 1'b0;
                            state     <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    // The count guard keeps out_cnt bounded even if work were corrupted.
                    if (work[WIDTH-1] || (cnt >= CNT_LAST)) begin
                        state <= ST_DONE;
                    end else begin
                        work <= {work[WIDTH-2:0], 1'b0};
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        zero_flag <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign out_data  = work;
    assign out_cnt   = cnt;

`ifdef NORM_ZERO_FLAG_EN
    assign out_zero = zero_flag && (state == ST_DONE);
`else
    logic unused_zero;
    assign unused_zero = zero_flag;
`endif

endmodule

// File: tb/tb_iterative_normalizer.sv
// Self-checking bench for iterative_normalizer: directed vector table, reset-in-flight
// sequence and randomized operands checked against an arithmetic leading-zero model.
module tb_iterative_normalizer;

    logic       clk;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic [3:0] out_cnt;
    logic       out_valid;
    logic       out_ready;
`ifdef NORM_ZERO_FLAG_EN
    logic       out_zero;
`endif

    int checks   = 0;
    int failures = 0;

    iterative_normalizer dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef NORM_ZERO_FLAG_EN
        ,
        .out_zero  (out_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        int         exp_data;
        int         exp_cnt;
        int         exp_edges;
        int         hold;
        bit         junk;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Leading zeros from the bit length of the operand; zero maps to 8.
    function automatic int model_lz(input logic [7:0] d);
        return 8 - $clog2(int'(d) + 1);
    endfunction

    function automatic int model_data(input logic [7:0] d);
        return (int'(d) * (1 << model_lz(d))) % 256;
    endfunction

    function automatic int model_edges(input logic [7:0] d);
        return (d == 8'h00) ? 1 : model_lz(d) + 2;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Edge count includes the accepting edge; hold = cycles spent in DONE with out_ready low.
    task automatic applyStimulus(input string name, input logic [7:0] d, input int exp_data,
                                 input int exp_cnt, input int exp_edges, input int hold,
                                 input bit junk);
        int edges;
        checkOutput({name, " in_ready_before"}, int'(in_ready), 1);
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        edges = 1;
        if (!junk) in_valid = 1'b0;
        else       in_data  = 8'($urandom);
        while (!out_valid && edges < 40) begin
            checkOutput({name, " in_ready_busy"}, int'(in_ready), 0);
            tick();
            edges++;
            if (junk) in_data = 8'($urandom);
        end
        checkOutput({name, " latency"}, edges, exp_edges);
        checkOutput({name, " out_data"}, int'(out_data), exp_data);
        checkOutput({name, " out_cnt"}, int'(out_cnt), exp_cnt);
`ifdef NORM_ZERO_FLAG_EN
        checkOutput({name, " out_zero"}, int'(out_zero), int'(d == 8'h00));
`endif
        for (int i = 0; i < hold; i++) begin
            tick();
            if (junk) in_data = 8'($urandom);
            checkOutput({name, " hold_valid"}, int'(out_valid), 1);
            checkOutput({name, " hold_data"}, int'(out_data), exp_data);
            checkOutput({name, " hold_cnt"}, int'(out_cnt), exp_cnt);
            checkOutput({name, " hold_in_ready"}, int'(in_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checkOutput({name, " idle_in_ready"}, int'(in_ready), 1);
        checkOutput({name, " idle_out_valid"}, int'(out_valid), 0);
`ifdef NORM_ZERO_FLAG_EN
        checkOutput({name, " idle_out_zero"}, int'(out_zero), 0);
`endif
    endtask

    initial begin
        vecs[0] = '{8'h80, 'h80, 0, 2, 0, 1'b0};
        vecs[1] = '{8'h01, 'h80, 7, 9, 0, 1'b0};
        vecs[2] = '{8'h13, 'h98, 3, 5, 0, 1'b0};
        vecs[3] = '{8'h00, 'h00, 8, 1, 0, 1'b0};
        vecs[4] = '{8'h20, 'h80, 2, 4, 5, 1'b0};
        vecs[5] = '{8'hFF, 'hFF, 0, 2, 1, 1'b0};
        vecs[6] = '{8'h7F, 'hFE, 1, 3, 2, 1'b1};
        vecs[7] = '{8'h01, 'h80, 7, 9, 3, 1'b1};

        rst       = 1'b1;
        in_data   = 8'h00;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset out_data", int'(out_data), 0);
        checkOutput("reset out_cnt", int'(out_cnt), 0);
        out_ready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i].din, vecs[i].exp_data,
                          vecs[i].exp_cnt, vecs[i].exp_edges, vecs[i].hold, vecs[i].junk);
        end

        // Reset lands on the third SHIFT cycle of a long operand.
        in_data  = 8'h01;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("midshift_rst in_ready", int'(in_ready), 1);
        checkOutput("midshift_rst out_valid", int'(out_valid), 0);
        checkOutput("midshift_rst out_cnt", int'(out_cnt), 0);
        checkOutput("midshift_rst out_data", int'(out_data), 0);
        applyStimulus("after_rst", 8'h40, 'h80, 1, 3, 0, 1'b0);

        // Reset while holding in DONE.
        in_data  = 8'h00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        checkOutput("done_rst pre_valid", int'(out_valid), 1);
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst = 1'b0;
        checkOutput("done_rst out_valid", int'(out_valid), 0);
        checkOutput("done_rst out_cnt", int'(out_cnt), 0);

        for (int i = 0; i < 30; i++) begin
            logic [7:0] d;
            d = (i % 10 == 0) ? 8'h00 : 8'($urandom >> (i % 8));
            applyStimulus($sformatf("rand%0d_%02h", i, d), d, model_data(d), model_lz(d),
                          model_edges(d), int'($urandom_range(0, 2)), 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iterative_normalizer.md
ITERATIVE_NORMALIZER -- requirements
Module: iterative_normalizer

Interface
REQ-001 Parameter WIDTH, default 8, data path width in bits; the bench uses the default only.
REQ-002 Parameter CNT_W, default 4, shift-count width, SHALL satisfy 2^CNT_W > WIDTH.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  operand to normalize.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block can accept an operand.
REQ-008 out_data  output  WIDTH  normalized operand, left-shifted until MSB=1.
REQ-009 out_cnt  output  CNT_W  number of left shifts applied, equal to leading-zero count.
REQ-010 out_valid  output  1  out_data/out_cnt valid.
REQ-011 out_ready  input  1  consumer accepts result.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE; in_ready SHALL equal (state==IDLE).
REQ-013 IDLE, in_valid=1: capture in_data into working reg, clear count; nonzero -> SHIFT, zero -> DONE with count=WIDTH and data=0.
REQ-014 SHIFT, working reg MSB=1: -> DONE, reg and count unchanged.
REQ-015 SHIFT, working reg MSB=0: logical left shift by 1 with zero fill, count+1, stay in SHIFT.
REQ-016 Latency: operand with k leading zeros (1 <= k+1 <= WIDTH) accepted at edge T, out_valid first high after edge T+k+2; zero operand, out_valid high after edge T+1.
REQ-017 out_valid SHALL equal (state==DONE); out_data and out_cnt SHALL be driven from registers and held stable while out_valid=1.
REQ-018 DONE, out_ready=1: -> IDLE on that edge; DONE, out_ready=0: hold all outputs unchanged.
REQ-019 in_valid outside IDLE SHALL be ignored, with no capture and no state change.
REQ-020 Back-to-back: no bypass; the next operand is accepted earliest on the first IDLE cycle after the DONE handshake.
REQ-021 out_cnt SHALL never exceed WIDTH; no shift SHALL occur beyond count WIDTH-1.
REQ-022 out_ready outside DONE SHALL have no effect.

Reset
REQ-023 rst=1 at a rising edge SHALL force state=IDLE, working reg=0, count=0, regardless of current state, including mid-SHIFT and DONE.
REQ-024 Post-reset outputs: in_ready=1, out_valid=0, out_data=0, out_cnt=0.
REQ-025 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-026 Macro NORM_ZERO_FLAG_EN: when defined, the block SHALL add output out_zero (1 bit), registered, =1 in DONE iff the captured operand was 0, and =0 at reset and in all other states.
REQ-027 Without NORM_ZERO_FLAG_EN, port out_zero SHALL be absent, and a zero operand SHALL be identified only by out_cnt==WIDTH; all other behaviour is identical.

Verification
REQ-028 in_data=0x80, out_ready=1 -> out_valid after 2 edges, out_data=0x80, out_cnt=0.
REQ-029 in_data=0x01, out_ready=1 -> out_valid after 9 edges, out_data=0x80, out_cnt=7; in_data=0x13 -> out_data=0x98, out_cnt=3.
REQ-030 in_data=0x00 -> out_valid after 1 edge, out_data=0x00, out_cnt=8; with NORM_ZERO_FLAG_EN, out_zero=1.
REQ-031 in_data=0x20, out_ready held 0 for 5 cycles in DONE -> out_data=0x80 and out_cnt=2 stable; in_ready=0 throughout; IDLE one edge after out_ready=1.
REQ-032 in_data=0x01 accepted, rst=1 on 3rd SHIFT cycle -> next cycle in_ready=1, out_valid=0, out_cnt=0; new operand 0x40 -> out_cnt=1.
REQ-033 in_valid held 1 with changing in_data during SHIFT/DONE -> result reflects only the first captured operand.
